rsa_job_ctrl: RTL and testbench
===============================

# rsa_job_ctrl

Job-level sequencer for the RSA exponentiation datapath. Sits between the UART byte receiver/transmitter and the operand loader, the Montgomery exponentiation core and the result serializer. It frames one job from a fixed-length byte stream, starts the exponentiation once operands are in BRAM, captures the answer and returns it byte-by-byte under the transmitter's busy handshake. It flags timeouts and overrun errors.

## Interface
- N, 16, operand/result width in bits; multiple of 8
- LOAD_BYTES, 10, bytes per job frame (header + operands) forwarded to the loader
- TIMEOUT, 65535, max cycles spent waiting in LOAD (between bytes), WAIT_LD or RUN
- TW, 16, timeout counter width; TIMEOUT < 2^TW

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe: rx_byte valid from UART receiver
- rx_byte  in  8  received byte
- ld_valid  out  1  one-cycle strobe to operand loader
- ld_byte  out  8  byte to operand loader
- ld_done  in  1  loader reports operands written (level or pulse)
- exp_start  out  1  one-cycle start pulse to exponentiation core
- exp_stop  in  1  core reports completion
- exp_ans  in  N  core result, valid while exp_stop high
- tx_busy  in  1  UART transmitter busy
- tx_valid  out  1  one-cycle strobe: send tx_byte
- tx_byte  out  8  byte to transmitter
- busy  out  1  high in every state except IDLE
- err_timeout  out  1  sticky: a wait exceeded TIMEOUT
- err_overrun  out  1  sticky: byte received while not accepting

## Operation
- States: IDLE, LOAD, WAIT_LD, START, RUN, SEND, TXWAIT.
- IDLE: on rx_valid, forward the byte, clear both error flags, set byte count to 1, go to LOAD. If LOAD_BYTES==1, go straight to WAIT_LD.
- LOAD: each rx_valid forwards one byte and increments the count. On the LOAD_BYTES-th byte go to WAIT_LD. Timeout counter clears on every byte.
- WAIT_LD: on ld_done go to START. ld_done outside WAIT_LD is ignored.
- START: exp_start=1 for exactly one cycle, then RUN.
- RUN: on exp_stop, latch exp_ans into the result register, set the byte index to N/8-1, go to SEND. exp_stop outside RUN is ignored.
- SEND: when tx_busy==0, pulse tx_valid with result byte [index*8+7:index*8] (MSB byte first), then go to TXWAIT.
- TXWAIT: one guard cycle, then wait for tx_busy==0. If bytes remain, decrement the index and go to SEND. Otherwise go to IDLE.
- Timeout: the counter clears on every state entry and counts in LOAD, WAIT_LD and RUN. When it reaches TIMEOUT: set err_timeout, go to IDLE, discard the partial job.
- Overrun: rx_valid in WAIT_LD, START, RUN, SEND or TXWAIT sets err_overrun. The byte is dropped and the state is unchanged.
- Simultaneous timeout and event in the same cycle: the event wins, no error.
- Errors clear only on rst or on the first byte of the next job.

## Timing
- Reset values: state IDLE; ld_valid, exp_start, tx_valid, busy, err_timeout, err_overrun = 0; ld_byte, tx_byte = 0; counters and result register = 0.
- rst mid-job aborts immediately; no pending strobe is emitted. Downstream blocks share the same rst.
- ld_valid/ld_byte are registered: asserted 1 cycle after the rx_valid that carried the byte.
- ld_done seen in cycle t: exp_start is high in cycle t+2 (WAIT_LD→START, then pulse from register).
- exp_stop seen in cycle t: the first tx_valid comes no earlier than t+2.
- Strobes are single-cycle and never back-to-back: minimum 3 cycles between tx_valid pulses.
- busy rises the cycle after the first accepted byte and falls the cycle after the last TXWAIT exits.

## Test plan
- Normal job (N=16, LOAD_BYTES=10): bytes 0A,08,01,B3,02,3B,01,2C,02,4D → 10 ld_valid strobes with identical bytes; ld_done → one exp_start; exp_stop with exp_ans=0x1234 → tx_byte 0x12 then 0x34, each gated by tx_busy; ends in IDLE with busy=0.
- TX backpressure: hold tx_busy=1 for 50 cycles after the first byte → second tx_valid only after tx_busy falls; exactly 2 strobes total.
- Load timeout (TIMEOUT=100): send 3 bytes then stop → err_timeout=1 at 100 cycles after the third byte; state IDLE; a new frame clears err_timeout and completes normally.
- Run timeout: withhold exp_stop → err_timeout after 100 cycles in RUN; no tx_valid emitted.
- Overrun: inject rx_valid (0xFF) during RUN → err_overrun=1, no extra ld_valid, job still completes with the correct result.
- Reset mid-SEND: assert rst after the first tx byte → all outputs 0 next cycle, no second tx_valid; the next frame runs cleanly.

Source files
------------

// File: rtl/rsa_job_ctrl.sv
// rsa_job_ctrl: frames an RSA job from UART bytes, runs the exponentiation core and streams the result back
module rsa_job_ctrl #(
  parameter int N = 16,
  parameter int LOAD_BYTES = 10,
  parameter int TIMEOUT = 65535,
  parameter int TW = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [7:0]   rx_byte,
  output logic         ld_valid,
  output logic [7:0]   ld_byte,
  input  logic         ld_done,
  output logic         exp_start,
  input  logic         exp_stop,
  input  logic [N-1:0] exp_ans,
  input  logic         tx_busy,
  output logic         tx_valid,
  output logic [7:0]   tx_byte,
  output logic         busy,
  output logic         err_timeout,
  output logic         err_overrun
);
  localparam int CW = $clog2(LOAD_BYTES + 1);
  localparam int IW = N > 8 ? $clog2(N / 8) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_LD, START, RUN, SEND, TXWAIT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmr;
  logic [N-1:0] res;
  logic [IW-1:0] idx;
  logic guard;
  logic tmo;
  assign tmo = tmr == TW'(TIMEOUT - 1);
  assign busy = state != IDLE;
  // result register shifts left per byte so the outgoing byte is always the top one
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      tmr <= '0;
      res <= '0;
      idx <= '0;
      guard <= 1'b0;
      ld_valid <= 1'b0;
      ld_byte <= '0;
      exp_start <= 1'b0;
      tx_valid <= 1'b0;
      tx_byte <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      ld_valid <= 1'b0;
      exp_start <= 1'b0;
      tx_valid <= 1'b0;
      tmr <= (state == LOAD || state == WAIT_LD || state == RUN) ? tmr + 1'b1 : '0;
      if (rx_valid && state != IDLE && state != LOAD) err_overrun <= 1'b1;
      case (state)
        IDLE: if (rx_valid) begin
          ld_valid <= 1'b1;
          ld_byte <= rx_byte;
          err_timeout <= 1'b0;
          err_overrun <= 1'b0;
          cnt <= CW'(1);
          state <= LOAD_BYTES == 1 ? WAIT_LD : LOAD;
        end
        LOAD: if (rx_valid) begin
          ld_valid <= 1'b1;
          ld_byte <= rx_byte;
          cnt <= cnt + 1'b1;
          tmr <= '0;
          if (cnt == CW'(LOAD_BYTES - 1)) state <= WAIT_LD;
        end else if (tmo) begin
          err_timeout <= 1'b1;
          state <= IDLE;
        end
        WAIT_LD: if (ld_done) state <= START;
        else if (tmo) begin
          err_timeout <= 1'b1;
          state <= IDLE;
        end
        START: begin
          exp_start <= 1'b1;
          state <= RUN;
        end
        RUN: if (exp_stop) begin
          res <= exp_ans;
          idx <= IW'(N / 8 - 1);
          state <= SEND;
        end else if (tmo) begin
          err_timeout <= 1'b1;
          state <= IDLE;
        end
        SEND: if (!tx_busy) begin
          tx_valid <= 1'b1;
          tx_byte <= res[N-1 -: 8];
          guard <= 1'b1;
          state <= TXWAIT;
        end
        TXWAIT: if (guard) guard <= 1'b0;
        else if (!tx_busy) begin
          if (idx != '0) begin
            idx <= idx - 1'b1;
            res <= res << 8;
            state <= SEND;
          end else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_job_ctrl.sv
// tb_rsa_job_ctrl: directed scenario bench for the RSA job sequencer (N=16, 10-byte frames, TIMEOUT=100)
module tb_rsa_job_ctrl;
  logic clk = 0, rst = 1, rx_valid = 0, ld_done = 0, exp_stop = 0, tx_busy = 0;
  logic [7:0] rx_byte = 0;
  logic [15:0] exp_ans = 0;
  logic ld_valid, exp_start, tx_valid, busy, err_timeout, err_overrun;
  logic [7:0] ld_byte, tx_byte;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, ld_n = 0, ex_n = 0, tx_n = 0;
  logic [7:0] ld_log [256];
  logic [7:0] tx_log [256];
  int tx_cyc [256];
  logic [7:0] frame [10] = '{8'h0A, 8'h08, 8'h01, 8'hB3, 8'h02, 8'h3B, 8'h01, 8'h2C, 8'h02, 8'h4D};

  rsa_job_ctrl #(.N(16), .LOAD_BYTES(10), .TIMEOUT(100), .TW(16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_done(ld_done),
    .exp_start(exp_start), .exp_stop(exp_stop), .exp_ans(exp_ans),
    .tx_busy(tx_busy), .tx_valid(tx_valid), .tx_byte(tx_byte),
    .busy(busy), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // strobe monitor: sees pre-edge output values, stamps each pulse with the cycle it was visible in
  always @(posedge clk) begin
    if (ld_valid) begin ld_log[ld_n % 256] = ld_byte; ld_n++; end
    if (exp_start) ex_n++;
    if (tx_valid) begin tx_log[tx_n % 256] = tx_byte; tx_cyc[tx_n % 256] = cyc; tx_n++; end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1; rx_byte = b;
    @(negedge clk);
    rx_valid = 0; rx_byte = 0;
  endtask

  task automatic load_frame();
    int b0 = ld_n;
    int bad = 0;
    for (int i = 0; i < 10; i++) send_byte(frame[i]);
    tick(1);
    n_cmp++;
    if (ld_n - b0 !== 10) begin n_bad++; $display("FAIL ld_count: got %0d want 10", ld_n - b0); end
    for (int i = 0; i < 10; i++) if (ld_log[(b0 + i) % 256] !== frame[i]) bad++;
    n_cmp++;
    if (bad !== 0) begin n_bad++; $display("FAIL ld_bytes: %0d bytes differ from frame, want 0", bad); end
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_loaded: got %b want 1", busy); end
  endtask

  task automatic start_core();
    int t;
    int k = 0;
    tick(2);
    ld_done = 1; t = cyc;
    @(negedge clk);
    ld_done = 0;
    while (exp_start !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    n_cmp++;
    if (exp_start !== 1'b1 || cyc - t !== 2)
      begin n_bad++; $display("FAIL exp_start_latency: got %0d cycles (start=%b) want 2", cyc - t, exp_start); end
  endtask

  task automatic finish_tx(input logic [15:0] ans);
    int t;
    int k = 0;
    int b0 = tx_n;
    exp_ans = ans; exp_stop = 1; t = cyc;
    @(negedge clk);
    exp_stop = 0; exp_ans = 0;
    while (tx_n - b0 < 2 && k < 100) begin @(negedge clk); k++; end
    n_cmp++;
    if (tx_n - b0 !== 2) begin n_bad++; $display("FAIL tx_count: got %0d want 2", tx_n - b0); end
    n_cmp++;
    if ({tx_log[b0 % 256], tx_log[(b0 + 1) % 256]} !== ans)
      begin n_bad++; $display("FAIL tx_bytes: got %h%h want %h", tx_log[b0 % 256], tx_log[(b0 + 1) % 256], ans); end
    n_cmp++;
    if (tx_cyc[b0 % 256] - t !== 2) begin n_bad++; $display("FAIL tx_latency: got %0d want 2", tx_cyc[b0 % 256] - t); end
    n_cmp++;
    if (tx_cyc[(b0 + 1) % 256] - tx_cyc[b0 % 256] < 3)
      begin n_bad++; $display("FAIL tx_spacing: got %0d want >=3", tx_cyc[(b0 + 1) % 256] - tx_cyc[b0 % 256]); end
    tick(3);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_done: got %b want 0", busy); end
  endtask

  task automatic test_reset();
    tick(3);
    n_cmp++;
    if ({ld_valid, exp_start, tx_valid, busy, err_timeout, err_overrun} !== 6'b0)
      begin n_bad++; $display("FAIL reset_flags: got %b want 000000", {ld_valid, exp_start, tx_valid, busy, err_timeout, err_overrun}); end
    n_cmp++;
    if ({ld_byte, tx_byte} !== 16'h0) begin n_bad++; $display("FAIL reset_bytes: got %h want 0000", {ld_byte, tx_byte}); end
    rst = 0;
    tick(2);
  endtask

  task automatic test_normal();
    int e0 = ex_n;
    load_frame();
    start_core();
    tick(3);
    finish_tx(16'h1234);
    n_cmp++;
    if (ex_n - e0 !== 1) begin n_bad++; $display("FAIL exp_start_count: got %0d want 1", ex_n - e0); end
  endtask

  task automatic test_backpressure();
    int b0 = tx_n;
    int k = 0;
    int t_fall;
    load_frame();
    start_core();
    exp_ans = 16'hABCD; exp_stop = 1;
    @(negedge clk);
    exp_stop = 0; exp_ans = 0;
    while (tx_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    tx_busy = 1;
    tick(50);
    n_cmp++;
    if (tx_n - b0 !== 1) begin n_bad++; $display("FAIL bp_hold: got %0d strobes want 1", tx_n - b0); end
    tx_busy = 0; t_fall = cyc;
    tick(10);
    n_cmp++;
    if (tx_n - b0 !== 2) begin n_bad++; $display("FAIL bp_total: got %0d strobes want 2", tx_n - b0); end
    n_cmp++;
    if (tx_cyc[(b0 + 1) % 256] <= t_fall) begin n_bad++; $display("FAIL bp_order: tx at %0d want after %0d", tx_cyc[(b0 + 1) % 256], t_fall); end
    n_cmp++;
    if ({tx_log[b0 % 256], tx_log[(b0 + 1) % 256]} !== 16'hABCD)
      begin n_bad++; $display("FAIL bp_bytes: got %h%h want abcd", tx_log[b0 % 256], tx_log[(b0 + 1) % 256]); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_idle: got %b want 0", busy); end
  endtask

  task automatic test_load_timeout();
    int b0 = ld_n;
    for (int i = 0; i < 3; i++) send_byte(frame[i]);
    tick(99);
    n_cmp++;
    if ({err_timeout, busy} !== 2'b01) begin n_bad++; $display("FAIL ld_tmo_early: got err=%b busy=%b want 0 1", err_timeout, busy); end
    tick(1);
    n_cmp++;
    if ({err_timeout, busy} !== 2'b10) begin n_bad++; $display("FAIL ld_tmo: got err=%b busy=%b want 1 0", err_timeout, busy); end
    n_cmp++;
    if (ld_n - b0 !== 3) begin n_bad++; $display("FAIL ld_tmo_bytes: got %0d want 3", ld_n - b0); end
    load_frame();
    n_cmp++;
    if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL ld_tmo_clear: got %b want 0", err_timeout); end
    start_core();
    finish_tx(16'h0F0F);
  endtask

  task automatic test_run_timeout();
    int b0 = tx_n;
    load_frame();
    start_core();
    tick(99);
    n_cmp++;
    if ({err_timeout, busy} !== 2'b01) begin n_bad++; $display("FAIL run_tmo_early: got err=%b busy=%b want 0 1", err_timeout, busy); end
    tick(1);
    n_cmp++;
    if ({err_timeout, busy} !== 2'b10) begin n_bad++; $display("FAIL run_tmo: got err=%b busy=%b want 1 0", err_timeout, busy); end
    exp_ans = 16'hFFFF; exp_stop = 1;
    @(negedge clk);
    exp_stop = 0; exp_ans = 0;
    tick(5);
    n_cmp++;
    if (tx_n - b0 !== 0 || busy !== 1'b0) begin n_bad++; $display("FAIL run_tmo_tx: got %0d strobes busy=%b want 0 0", tx_n - b0, busy); end
  endtask

  task automatic test_overrun();
    int b0;
    int e0;
    load_frame();
    b0 = ld_n;
    start_core();
    tick(2);
    send_byte(8'hFF);
    tick(1);
    n_cmp++;
    if ({err_overrun, busy} !== 2'b11) begin n_bad++; $display("FAIL ovr_flag: got err=%b busy=%b want 1 1", err_overrun, busy); end
    n_cmp++;
    if (ld_n - b0 !== 0) begin n_bad++; $display("FAIL ovr_ld: got %0d extra strobes want 0", ld_n - b0); end
    finish_tx(16'h5AA5);
    n_cmp++;
    if (err_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", err_overrun); end
    e0 = ex_n;
    ld_done = 1; exp_stop = 1;
    @(negedge clk);
    ld_done = 0; exp_stop = 0;
    tick(3);
    n_cmp++;
    if (busy !== 1'b0 || ex_n - e0 !== 0) begin n_bad++; $display("FAIL idle_ignore: got busy=%b starts=%0d want 0 0", busy, ex_n - e0); end
    send_byte(frame[0]);
    n_cmp++;
    if (err_overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b want 0", err_overrun); end
    for (int i = 1; i < 10; i++) send_byte(frame[i]);
    start_core();
    finish_tx(16'hC3E1);
  endtask

  task automatic test_reset_mid_send();
    int b0 = tx_n;
    int k = 0;
    load_frame();
    start_core();
    exp_ans = 16'hBEEF; exp_stop = 1;
    @(negedge clk);
    exp_stop = 0; exp_ans = 0;
    while (tx_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    rst = 1;
    @(negedge clk);
    n_cmp++;
    if ({ld_valid, exp_start, tx_valid, busy, err_timeout, err_overrun, ld_byte, tx_byte} !== 22'b0)
      begin n_bad++; $display("FAIL rst_mid: got %b %h %h want all 0", {ld_valid, exp_start, tx_valid, busy, err_timeout, err_overrun}, ld_byte, tx_byte); end
    rst = 0;
    tick(10);
    n_cmp++;
    if (tx_n - b0 !== 1 || tx_log[b0 % 256] !== 8'hBE)
      begin n_bad++; $display("FAIL rst_tx: got %0d strobes first=%h want 1 be", tx_n - b0, tx_log[b0 % 256]); end
    load_frame();
    start_core();
    finish_tx(16'h1234);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_load_timeout();
    test_run_timeout();
    test_overrun();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
